// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator for the video output path. Walks full horizontal
//   and vertical periods (active + front porch + sync + back porch) at the
//   pixel rate. The counters advance only on cycles where clk_en is high.
//   Every output is decoded from the counter values being loaded and is
//   registered on the same edge. Outputs therefore line up with x_pos/y_pos
//   with no extra latency.
//
// Ports
//   CLK_40       in   1        pixel-domain clock
//   reset_n      in   1        synchronous reset, active-low
//   clk_en       in   1        pixel advance enable; counters hold when low
//   x_pos        out  X_W      horizontal count, 0..H_TOTAL-1
//   y_pos        out  Y_W      vertical count, 0..V_TOTAL-1
//   active       out  1        visible-area flag
//   hsync        out  1        horizontal sync, polarity HS_POL
//   vsync        out  1        vertical sync, polarity VS_POL
//   line_start   out  1        one-cycle strobe when x_pos enters 0
//   frame_start  out  1        one-cycle strobe when (x_pos,y_pos) enters (0,0)
//   frame_cnt    out  FRAME_W  number of the current frame
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int FRAME_W  = 16,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int X_W     = $clog2(H_TOTAL),
    localparam int Y_W     = $clog2(V_TOTAL)
) (
    input  logic               CLK_40,
    input  logic               reset_n,
    input  logic               clk_en,
    output logic [X_W-1:0]     x_pos,
    output logic [Y_W-1:0]     y_pos,
    output logic               active,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || FRAME_W < 1) begin : g_param_check
            $error("vga_timing_gen: every timing parameter and FRAME_W must be >= 1");
        end
    endgenerate

    // Decode boundaries. Because each porch is at least one pixel or line,
    // every boundary is at most TOTAL-1 and fits the counter width.
    localparam logic [X_W-1:0] X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0] X_ACT    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] Y_ACT    = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0] HS_START = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] VS_START = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic               r_active;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_line_start;
    logic               r_frame_start;
    logic [FRAME_W-1:0] r_frame_cnt;

    logic               w_x_last;
    logic               w_y_last;
    logic [X_W-1:0]     w_x_next;
    logic [Y_W-1:0]     w_y_next;
    logic               w_frame_wrap;

    always_comb begin
        w_x_last     = (r_x == X_LAST);
        w_y_last     = (r_y == Y_LAST);
        w_x_next     = w_x_last ? '0 : r_x + X_W'(1);
        // y only moves on the line wrap, so vsync can only change with x_pos = 0.
        w_y_next     = w_x_last ? (w_y_last ? '0 : r_y + Y_W'(1)) : r_y;
        w_frame_wrap = w_x_last && w_y_last;
    end

    // The reset values are the decode of the last pixel of a frame, so the
    // first enabled edge after reset lands on (0,0), raises frame_start and
    // moves frame_cnt from all-ones to 0.
    always_ff @(posedge CLK_40) begin
        if (!reset_n) begin
            r_x           <= X_LAST;
            r_y           <= Y_LAST;
            r_active      <= 1'b0;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '1;
        end else if (clk_en) begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_active      <= (w_x_next < X_ACT) && (w_y_next < Y_ACT);
            r_hsync       <= ((w_x_next >= HS_START) && (w_x_next < HS_END)) ? HS_POL : ~HS_POL;
            r_vsync       <= ((w_y_next >= VS_START) && (w_y_next < VS_END)) ? VS_POL : ~VS_POL;
            r_line_start  <= w_x_last;
            r_frame_start <= w_frame_wrap;
            if (w_frame_wrap) begin
                r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
            end
        end else begin
            // Hold position and levels; strobes last only the enabled cycle.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign x_pos       = r_x;
    assign y_pos       = r_y;
    assign active      = r_active;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default 800x600 configuration
  logic        rst_n, en;
  logic [10:0] d_x;
  logic [9:0]  d_y;
  logic        d_act, d_hs, d_vs, d_ls, d_fs;
  logic [15:0] d_fc;

  // small configuration: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), low sync
  logic        s_rst_n, s_en;
  logic [2:0]  s_x;
  logic [2:0]  s_y;
  logic        s_act, s_hs, s_vs, s_ls, s_fs;
  logic [3:0]  s_fc;

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing_gen u_dut (
    .CLK_40(clk), .reset_n(rst_n), .clk_en(en),
    .x_pos(d_x), .y_pos(d_y), .active(d_act), .hsync(d_hs), .vsync(d_vs),
    .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .FRAME_W(4)
  ) u_small (
    .CLK_40(clk), .reset_n(s_rst_n), .clk_en(s_en),
    .x_pos(s_x), .y_pos(s_y), .active(s_act), .hsync(s_hs), .vsync(s_vs),
    .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // advance one clock, then sample away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_x, exp_y, prev_x, exp_ls;
  int sx, sy, sfc, sfs, sls, last_fs;

  initial begin
    rst_n = 1'b0; en = 1'b0; s_rst_n = 1'b0; s_en = 1'b0;

    // 1. reset state
    repeat (3) tick();
    check("rst_x",  32'(d_x), 1055);
    check("rst_y",  32'(d_y), 627);
    check("rst_act", 32'(d_act), 0);
    check("rst_hs", 32'(d_hs), 0);
    check("rst_vs", 32'(d_vs), 0);
    check("rst_ls", 32'(d_ls), 0);
    check("rst_fs", 32'(d_fs), 0);
    check("rst_fc", 32'(d_fc), 32'hFFFF);
    check("s_rst_hs", 32'(s_hs), 1);
    check("s_rst_vs", 32'(s_vs), 1);

    // 2. first enabled edge enters (0,0)
    rst_n = 1'b1; en = 1'b1;
    tick();
    check("first_x",  32'(d_x), 0);
    check("first_y",  32'(d_y), 0);
    check("first_act", 32'(d_act), 1);
    check("first_fs", 32'(d_fs), 1);
    check("first_ls", 32'(d_ls), 1);
    check("first_fc", 32'(d_fc), 0);
    check("first_hs", 32'(d_hs), 0);

    // 3. one full line
    for (int i = 1; i < 1056; i++) begin
      tick();
      check("line_x",   32'(d_x), 32'(i));
      check("line_y",   32'(d_y), 0);
      check("line_act", 32'(d_act), 32'(i < 800));
      check("line_hs",  32'(d_hs), 32'(i >= 840 && i <= 967));
      check("line_ls",  32'(d_ls), 0);
      check("line_fs",  32'(d_fs), 0);
    end
    tick();
    check("wrap_x",  32'(d_x), 0);
    check("wrap_y",  32'(d_y), 1);
    check("wrap_ls", 32'(d_ls), 1);
    check("wrap_fs", 32'(d_fs), 0);
    check("wrap_act", 32'(d_act), 1);
    check("wrap_fc", 32'(d_fc), 0);
    check("wrap_vs", 32'(d_vs), 0);

    // 5. clk_en toggling every cycle, crossing one line wrap
    exp_x = 0; exp_y = 1;
    for (int i = 0; i < 2 * 1056 + 4; i++) begin
      en = (i % 2 == 0);
      exp_ls = 0;
      if (en) begin
        prev_x = exp_x;
        if (exp_x == 1055) begin
          exp_x = 0; exp_y = exp_y + 1; exp_ls = 1;
        end else begin
          exp_x = exp_x + 1;
        end
      end
      tick();
      check("tog_x",  32'(d_x), 32'(exp_x));
      check("tog_y",  32'(d_y), 32'(exp_y));
      check("tog_ls", 32'(d_ls), 32'(exp_ls));
      check("tog_fs", 32'(d_fs), 0);
    end

    // 6. reset mid-line at x=400 with clk_en held high
    en = 1'b1;
    while (exp_x != 400) begin
      tick();
      exp_x = exp_x + 1;
    end
    check("pre_rst_x", 32'(d_x), 400);
    check("pre_rst_y", 32'(d_y), 2);
    rst_n = 1'b0;
    tick();
    check("mid_rst_x",  32'(d_x), 1055);
    check("mid_rst_y",  32'(d_y), 627);
    check("mid_rst_fc", 32'(d_fc), 32'hFFFF);
    check("mid_rst_act", 32'(d_act), 0);
    check("mid_rst_hs", 32'(d_hs), 0);
    rst_n = 1'b1; en = 1'b0;
    tick();
    check("hold_x",  32'(d_x), 1055);
    check("hold_fs", 32'(d_fs), 0);
    en = 1'b1;
    tick();
    check("restart_x",  32'(d_x), 0);
    check("restart_y",  32'(d_y), 0);
    check("restart_fs", 32'(d_fs), 1);
    check("restart_ls", 32'(d_ls), 1);
    check("restart_fc", 32'(d_fc), 0);
    en = 1'b0;

    // 7. small config, two frames plus a few pixels
    s_rst_n = 1'b1; s_en = 1'b1;
    sx = 7; sy = 5; sfc = 15; last_fs = -1;
    for (int c = 1; c <= 100; c++) begin
      if (sx == 7) begin
        sx = 0;
        sy = (sy == 5) ? 0 : sy + 1;
      end else begin
        sx = sx + 1;
      end
      sls = (sx == 0);
      sfs = (sx == 0 && sy == 0);
      if (sfs) sfc = (sfc + 1) % 16;
      tick();
      check("s_x",   32'(s_x), 32'(sx));
      check("s_y",   32'(s_y), 32'(sy));
      check("s_act", 32'(s_act), 32'(sx < 4 && sy < 3));
      check("s_hs",  32'(s_hs), 32'(!(sx == 5 || sx == 6)));
      check("s_vs",  32'(s_vs), 32'(sy != 4));
      check("s_ls",  32'(s_ls), 32'(sls));
      check("s_fs",  32'(s_fs), 32'(sfs));
      check("s_fc",  32'(s_fc), 32'(sfc));
      if (s_fs) begin
        if (last_fs >= 0) check("s_period", 32'(c - last_fs), 48);
        last_fs = c;
      end
    end
    check("s_fc_end", 32'(s_fc), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
